// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - borrow_in over N/W clocks, one W-bit chunk per clock.
// A registered borrow links the chunks, and valid/ready handshakes sit on both sides.
module serial_subtractor #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out
);
    localparam int C = (W > 0) ? N / W : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] LAST = CW'(C - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (W < 1 || W > N || N % ((W < 1) ? 1 : W) != 0) begin : g_bad_w
        $error("serial_subtractor: W must satisfy 1 <= W <= N and divide N");
    end

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_diff;
    logic          r_borrow;
    logic          r_borrow_out;
    logic [W:0]    w_sub;
    int            w_pos;

    // Operand registers shift right each chunk, so the live chunk is always the low W bits.
    assign w_sub = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - {{W{1'b0}}, r_borrow};
    assign w_pos = int'(r_cnt) * W;
    assign in_ready = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign diff = r_diff;
    assign borrow_out = r_borrow_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt <= '0;
            r_borrow <= 1'b0;
            r_diff <= '0;
            r_borrow_out <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_a <= a;
                r_b <= b;
                r_borrow <= borrow_in;
                r_cnt <= '0;
                r_diff <= '0;
                r_state <= S_CALC;
            end
        end else if (r_state == S_CALC) begin
            r_diff[w_pos +: W] <= w_sub[W-1:0];
            r_borrow <= w_sub[W];
            r_a <= r_a >> W;
            r_b <= r_b >> W;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_borrow_out <= w_sub[W];
                r_state <= S_DONE;
            end
        end else if (r_state == S_DONE) begin
            if (out_ready) r_state <= S_IDLE;
        end else begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scenarios on a W=4 instance plus randomized scoreboard runs for W in {1,2,4,8,16}.
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_s = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        borrow_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        borrow_out;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [15:0] m_qd[$];
    bit          m_qb[$];
    int          m_qk[$];
    bit          m_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.N(16), .W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
        .borrow_out(borrow_out)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer subtraction; a negative result is exactly the unsigned wrap.
    task automatic push_model(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                              inout logic [15:0] qd[$], inout bit qb[$], inout int qk[$]);
        int r;
        r = int'(av) - int'(bv) - int'(bi);
        qd.push_back(r[15:0]);
        qb.push_back(r < 0);
        qk.push_back(cyc + 1);
    endtask

    task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic bi, input bit push);
        int n = 0;
        @(posedge clk); #1;
        a = av; b = bv; borrow_in = bi; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("accept_timeout", n, 0);
        else if (push) push_model(av, bv, bi, m_qd, m_qb, m_qk);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_qd.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) chk("drain_timeout", n, 0);
        @(negedge clk);
        chk("ready_after_done", in_ready, 1);
        chk("valid_after_done", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (rst) m_seen = 0;
        else if (out_valid) begin
            if (!m_seen) begin
                m_seen = 1;
                chk("result_expected", m_qd.size() > 0, 1);
                if (m_qd.size() > 0) chk("latency", cyc - m_qk[0], 4);
            end
            if (out_ready) begin
                if (m_qd.size() > 0) begin
                    chk("diff", diff, m_qd.pop_front());
                    chk("borrow_out", borrow_out, m_qb.pop_front());
                    void'(m_qk.pop_front());
                end
                m_seen = 0;
            end
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int WG = 1 << g;
        logic        iv = 1'b0;
        logic        ir;
        logic        ov;
        logic        orr = 1'b0;
        logic        bi = 1'b0;
        logic        bo;
        logic [15:0] av = '0;
        logic [15:0] bv = '0;
        logic [15:0] dv;
        logic [15:0] qd[$];
        bit          qb[$];
        int          qk[$];
        bit          seen = 0;
        bit          fin = 0;

        serial_subtractor #(.N(16), .W(WG)) u_dut (
            .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir), .a(av), .b(bv),
            .borrow_in(bi), .out_valid(ov), .out_ready(orr), .diff(dv), .borrow_out(bo)
        );

        initial forever begin
            @(posedge clk); #1;
            orr = $urandom_range(0, 3) != 0;
        end

        initial begin
            wait (!rst_s);
            for (int i = 0; i < 1000; i++) begin
                int n;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1;
                av = 16'($urandom); bv = 16'($urandom); bi = 1'($urandom); iv = 1'b1; n = 0;
                while (!ir && n < 200) begin @(posedge clk); #1; n++; end
                if (n >= 200) chk($sformatf("w%0d_accept_timeout", WG), n, 0);
                else push_model(av, bv, bi, qd, qb, qk);
                @(posedge clk); #1;
                iv = 1'b0;
            end
            for (int n = 0; n < 500 && qd.size() != 0; n++) @(posedge clk);
            if (qd.size() != 0) chk($sformatf("w%0d_drain", WG), qd.size(), 0);
            fin = 1;
        end

        always @(negedge clk) begin
            if (!rst_s && ov) begin
                if (!seen) begin
                    seen = 1;
                    chk($sformatf("w%0d_result_expected", WG), qd.size() > 0, 1);
                    if (qd.size() > 0) chk($sformatf("w%0d_latency", WG), cyc - qk[0], 16 / WG);
                end
                if (orr) begin
                    if (qd.size() > 0) begin
                        chk($sformatf("w%0d_diff", WG), dv, qd.pop_front());
                        chk($sformatf("w%0d_borrow_out", WG), bo, qb.pop_front());
                        void'(qk.pop_front());
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_diff", diff, 0);
        chk("reset_borrow_out", borrow_out, 0);
        out_ready = 1'b1;
        op(16'h1234, 16'h0034, 1'b0, 1); wait_done();
        op(16'h0000, 16'h0001, 1'b0, 1); wait_done();
        op(16'h0000, 16'h0000, 1'b1, 1); wait_done();
        op(16'h8000, 16'h7FFF, 1'b1, 1); wait_done();
        out_ready = 1'b0;
        op(16'h5555, 16'h1111, 1'b0, 1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 6; i++) begin
            in_valid = i == 2;
            if (i == 2) begin a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b0; end
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_diff", diff, 16'h4444);
            chk("stall_borrow_out", borrow_out, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        op(16'hFFFF, 16'h0001, 1'b0, 1); wait_done();
        op(16'h1111, 16'h2222, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_diff", diff, 0);
        chk("rst_mid_borrow_out", borrow_out, 0);
        repeat (10) @(posedge clk);
        op(16'h00FF, 16'h000F, 1'b0, 1); wait_done();
        n = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin && g_sw[4].fin) && n < 80000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 80000) chk("sweep_timeout", n, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
